keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/sync_2ff.sv | 35 +++
 rtl/keypad_scanner.sv | 152 +++++++++++++++
 tb/tb_keypad_scanner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
//   Shared types and constants for the 4x4 matrix keypad scanner.
//   - state_t   : scanner FSM states
//   - COL_IDLE  : column drive pattern on entry to scanning (col0 low)
//   - KEYMAP    : hex code for each [row][col] position, col0 at left
//   - one_low   : true when exactly one active-low row is asserted
//   - low_index : index of the single low row (only meaningful if one_low)
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HOLD     = 2'd2
    } state_t;

    localparam logic [3:0] COL_IDLE = 4'b1110;

    // Row 3 carries the '*' and '#' keys, reported as E and F.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic one_low(input logic [3:0] rows);
        return (rows == 4'b1110) || (rows == 4'b1101) ||
               (rows == 4'b1011) || (rows == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-stage synchronizer for asynchronous level inputs.
//   Ports:
//     clk   - destination clock
//     rst   - asynchronous active-high reset, both stages load RESET_VAL
//     d_i   - asynchronous input bus
//     q_o   - synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad, debounces press and release, and
//   reports each accepted key once as a hex code with a one-cycle strobe.
//   Ports:
//     clk      - system clock (10 MHz)
//     rst      - asynchronous active-high reset
//     row_i    - keypad rows, active-low, asynchronous to clk
//     col_o    - keypad columns, active-low, exactly one low at a time
//     key_code - code of the last accepted key, held until the next accept
//     key_ce   - one-cycle pulse on the cycle key_code takes a new value;
//                there is no back-pressure, the consumer must take it then
//     key_busy - high while a key is being debounced or is held down
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 10000,
    parameter int DEBOUNCE_TICKS = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code,
    output logic       key_ce,
    output logic       key_busy
);

    localparam int SW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);

    logic [3:0]    rows_s;

    state_t        state_q,   state_d;
    logic [1:0]    col_q,     col_d;
    logic [SW-1:0] dwell_q,   dwell_d;
    logic [DW-1:0] deb_q,     deb_d;
    logic [3:0]    row_pat_q, row_pat_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    code_q,    code_d;
    logic          ce_q,      ce_d;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (row_i),
        .q_o (rows_s)
    );

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        dwell_d   = dwell_q;
        deb_d     = deb_q;
        row_pat_d = row_pat_q;
        row_idx_d = row_idx_q;
        code_d    = code_q;
        ce_d      = 1'b0;

        case (state_q)
            S_SCAN: begin
                // Rows are only trusted on the last dwell cycle, by which
                // time the synchronizer reflects the current column.
                if (dwell_q == SCAN_LAST) begin
                    dwell_d = '0;
                    if (one_low(rows_s)) begin
                        row_pat_d = rows_s;
                        row_idx_d = low_index(rows_s);
                        deb_d     = '0;
                        state_d   = S_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + SW'(1);
                end
            end

            S_DEBOUNCE: begin
                if (rows_s != row_pat_q) begin
                    state_d = S_SCAN;
                    col_d   = 2'd0;
                    dwell_d = '0;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    code_d  = KEYMAP[row_idx_q][col_q];
                    ce_d    = 1'b1;
                    deb_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end

            S_HOLD: begin
                // Counts consecutive all-released cycles; any low row restarts it.
                if (rows_s != 4'b1111) begin
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = S_SCAN;
                    col_d   = 2'd0;
                    dwell_d = '0;
                    deb_d   = '0;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end

            default: begin
                state_d = S_SCAN;
                col_d   = 2'd0;
                dwell_d = '0;
                deb_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_SCAN;
            col_q     <= 2'd0;
            dwell_q   <= '0;
            deb_q     <= '0;
            row_pat_q <= 4'b1111;
            row_idx_q <= 2'd0;
            code_q    <= 4'h0;
            ce_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            dwell_q   <= dwell_d;
            deb_q     <= deb_d;
            row_pat_q <= row_pat_d;
            row_idx_q <= row_idx_d;
            code_q    <= code_d;
            ce_q      <= ce_d;
        end
    end

    // col_q == 0 gives COL_IDLE; the column stays put outside S_SCAN.
    assign col_o    = ~(4'b0001 << col_q);
    assign key_code = code_q;
    assign key_ce   = ce_q;
    assign key_busy = (state_q != S_SCAN);

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Drives a modelled 4x4 keypad (a pressed key pulls its row low only while
//   its column is driven low) into keypad_scanner with SCAN_TICKS=4 and
//   DEBOUNCE_TICKS=8, and checks codes, strobes and scan behaviour.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_TICKS     = 4;
    localparam int DEBOUNCE_TICKS = 8;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_code;
    logic       key_ce;
    logic       key_busy;

    always #50 clk = ~clk;

    keypad_scanner #(
        .SCAN_TICKS     (SCAN_TICKS),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_i    (row_i),
        .col_o    (col_o),
        .key_code (key_code),
        .key_ce   (key_ce),
        .key_busy (key_busy)
    );

    // ---------------- keypad model ----------------
    logic [15:0] pressed;   // bit r*4+c set = key at row r, column c held down

    always_comb begin
        row_i = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
    end

    function automatic logic [15:0] key(input int r, input int c);
        logic [15:0] one16;
        one16 = 16'd1;
        return one16 << (r*4 + c);
    endfunction

    // ---------------- scoreboard ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];
    int         ce_count = 0;
    int         cyc      = 0;
    int         busy_rise_cyc = 0;
    logic       busy_seen = 1'b0;
    logic       prev_ce   = 1'b0;
    logic       prev_busy = 1'b0;
    logic [3:0] prev_col  = 4'b1110;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: pops the expected code on every strobe.
    always @(negedge clk) begin
        logic [3:0] exp_code;
        logic [3:0] zero4;
        cyc++;
        zero4 = 4'b0000;
        if (!rst) begin
            if (key_busy && !prev_busy) begin
                busy_rise_cyc = cyc;
                busy_seen     = 1'b1;
            end
            if (!key_busy && prev_busy) check("resume_col0", col_o, 4'b1110);
            if (key_busy && prev_busy)  check("col_frozen", col_o, prev_col);
            if (key_ce) begin
                ce_count++;
                check("ce_not_b2b", prev_ce, 0);
                check("ce_while_busy", key_busy, 1);
                // busy rises the cycle after detection; strobe is DEBOUNCE_TICKS+1 after detection
                check("ce_latency", cyc - busy_rise_cyc, DEBOUNCE_TICKS);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ce: code 0x%0h strobed, none expected", key_code);
                end else begin
                    exp_code = exp_q.pop_front();
                    check("key_code", key_code, exp_code);
                end
            end
        end else begin
            check("ce_low_in_reset", key_ce, zero4[0]);
        end
        prev_ce   = key_ce;
        prev_busy = key_busy;
        prev_col  = col_o;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_busy(input logic lvl, input int maxc, input string name);
        int n;
        n = 0;
        while (key_busy !== lvl && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (key_busy !== lvl) begin
            failures++;
            $display("FAIL %s: key_busy=%b after %0d cycles, wanted %b", name, key_busy, n, lvl);
        end
    endtask

    task automatic wait_ce(input int base, input int maxc, input string name);
        int n;
        n = 0;
        while (ce_count == base && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ce_count == base) begin
            failures++;
            $display("FAIL %s: no key_ce within %0d cycles (got %0d want 1)", name, maxc, 0);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_col"},  col_o,    4'b1110);
        check({name, "_code"}, key_code, 4'h0);
        check({name, "_ce"},   key_ce,   0);
        check({name, "_busy"}, key_busy, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] keys;
        int          hold;
        int          exp_pulses;
        logic [3:0]  exp_code;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        int         base;
        logic [3:0] one4;
        logic [3:0] exp_col;

        vecs[0]  = '{keys: key(1,1),            hold: 60,  exp_pulses: 1, exp_code: 4'h5};
        vecs[1]  = '{keys: key(3,0),            hold: 60,  exp_pulses: 1, exp_code: 4'hE};
        vecs[2]  = '{keys: key(3,2),            hold: 60,  exp_pulses: 1, exp_code: 4'hF};
        vecs[3]  = '{keys: key(0,1) | key(1,1), hold: 60,  exp_pulses: 0, exp_code: 4'h0};
        vecs[4]  = '{keys: key(2,2),            hold: 200, exp_pulses: 1, exp_code: 4'h9};
        vecs[5]  = '{keys: key(0,0),            hold: 60,  exp_pulses: 1, exp_code: 4'h1};
        vecs[6]  = '{keys: key(0,2),            hold: 60,  exp_pulses: 1, exp_code: 4'h3};
        vecs[7]  = '{keys: key(0,3),            hold: 60,  exp_pulses: 1, exp_code: 4'hA};
        vecs[8]  = '{keys: key(1,0),            hold: 60,  exp_pulses: 1, exp_code: 4'h4};
        vecs[9]  = '{keys: key(1,2),            hold: 60,  exp_pulses: 1, exp_code: 4'h6};
        vecs[10] = '{keys: key(1,3),            hold: 60,  exp_pulses: 1, exp_code: 4'hB};
        vecs[11] = '{keys: key(2,0),            hold: 60,  exp_pulses: 1, exp_code: 4'h7};
        vecs[12] = '{keys: key(2,1),            hold: 60,  exp_pulses: 1, exp_code: 4'h8};
        vecs[13] = '{keys: key(2,3),            hold: 60,  exp_pulses: 1, exp_code: 4'hC};
        vecs[14] = '{keys: key(3,1),            hold: 60,  exp_pulses: 1, exp_code: 4'h0};
        vecs[15] = '{keys: key(3,3),            hold: 60,  exp_pulses: 1, exp_code: 4'hD};
        vecs[16] = '{keys: key(0,1),            hold: 60,  exp_pulses: 1, exp_code: 4'h2};

        // ---- reset and column rotation ----
        pressed = 16'h0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst  = 1'b0;
        one4 = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if ((k % 4) == 0 || (k % 4) == 3) begin
                exp_col = ~(one4 << ((k / 4) % 4));
                check($sformatf("rotate_k%0d", k), col_o, exp_col);
            end
        end
        check("no_busy_idle", key_busy, 0);

        // ---- table-driven presses ----
        for (int i = 0; i < NV; i++) begin
            base      = ce_count;
            busy_seen = 1'b0;
            if (vecs[i].exp_pulses > 0) exp_q.push_back(vecs[i].exp_code);
            pressed = vecs[i].keys;
            repeat (vecs[i].hold) @(negedge clk);
            check($sformatf("pulses_v%0d", i), ce_count - base, vecs[i].exp_pulses);
            check($sformatf("busy_seen_v%0d", i), busy_seen, (vecs[i].exp_pulses > 0));
            if (vecs[i].exp_pulses > 0) begin
                check($sformatf("busy_held_v%0d", i), key_busy, 1);
                check($sformatf("code_held_v%0d", i), key_code, vecs[i].exp_code);
            end
            pressed = 16'h0;
            wait_busy(1'b0, 60, $sformatf("release_v%0d", i));
            repeat (4) @(negedge clk);
            if (exp_q.size() != 0) exp_q.delete();
        end

        // ---- bouncing key '5': never stable long enough ----
        base = ce_count;
        for (int t = 0; t < 10; t++) begin
            pressed = (t % 2 == 0) ? key(1,1) : 16'h0;
            repeat (3) @(negedge clk);
        end
        pressed = 16'h0;
        repeat (20) @(negedge clk);
        check("bounce_no_ce", ce_count - base, 0);
        check("bounce_idle", key_busy, 0);

        // ---- reset during HOLD ----
        base = ce_count;
        exp_q.push_back(4'h9);
        pressed = key(2,2);
        wait_ce(base, 80, "hold_reset_ce");
        repeat (3) @(negedge clk);
        check("in_hold_busy", key_busy, 1);
        #10 rst = 1'b1;
        #1 check_reset_outputs("rst_hold");
        pressed = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rst_hold_no_ce", ce_count - base, 1);

        // ---- reset during DEBOUNCE ----
        base = ce_count;
        pressed = key(1,1);
        wait_busy(1'b1, 40, "deb_busy");
        @(negedge clk);
        #10 rst = 1'b1;
        #1 check_reset_outputs("rst_deb");
        pressed = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_deb_no_ce", ce_count - base, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
